// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the Fusion ADC sweep sequencer.
// The alarm logic imports this package too, so it decodes channels the same way.
package adc_seq_pkg;

  // Channel 31 is the on-die temperature sensor.
  localparam int CH_INT_TEMP = 31;
  // Number of analogue quads, each with a voltage, a current and a temperature input.
  localparam int NUM_QUADS   = 10;

  // Sequencer states.
  typedef enum logic [2:0] {
    CAL_WAIT,
    IDLE,
    SCAN,
    STROBE,
    START,
    CONVERT,
    DONE
  } seq_state_e;

  // The kind of monitor a channel is wired to, which selects its settle strobe.
  typedef enum logic [1:0] {
    NONE,
    CURRENT,
    TEMP,
    TEMP_INT
  } chan_kind_e;

  // Any channel other than a plain voltage or reference input needs a settle strobe.
  function automatic logic kind_has_strobe(input chan_kind_e kind);
    return kind != NONE;
  endfunction

endpackage

// File: rtl/adc_chan_decode.sv
// Pure channel-number decoder. It maps an ADC channel onto its monitor kind and
// quad index. Channel 0 is the direct/reference input. Quad q owns channels 3q+1
// (voltage), 3q+2 (current) and 3q+3 (temperature). Channel 31 is the internal
// temperature sensor.
module adc_chan_decode
  import adc_seq_pkg::*;
(
  input  logic [4:0] ch,
  output chan_kind_e kind,
  output logic [3:0] quad
);

  logic [4:0] offset;
  logic [4:0] slot;

  // Split (ch - 1) into a quad index and a position within the quad.
  always_comb begin
    offset = ch - 5'd1;
    slot   = offset % 5'd3;
    kind   = NONE;
    quad   = '0;
    if (ch == 5'(CH_INT_TEMP)) begin
      kind = TEMP_INT;
    end else if (ch != 5'd0) begin
      quad = 4'(offset / 5'd3);
      case (slot)
        5'd1:    kind = CURRENT;
        5'd2:    kind = TEMP;
        default: kind = NONE;
      endcase
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Autonomous sweep controller for the Fusion ADC.
// It walks a latched 32-bit channel mask one channel per cycle. For each current
// or temperature channel it holds the matching monitor strobe for a settle period
// before the conversion. It then runs the ADC start/datavalid handshake, bounded
// by a timeout, and emits one tagged result per converted channel.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES  = 1600,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST,
  input  logic                 enable,
  input  logic [31:0]          ch_mask,
  output logic                 ADC_START,
  output logic [4:0]           ADC_CHNUM,
  input  logic                 ADC_CALIBRATE,
  input  logic                 ADC_BUSY,
  input  logic                 ADC_DATAVALID,
  input  logic [11:0]          ADC_RESULT,
  output logic [NUM_QUADS-1:0] cmstrb,
  output logic [NUM_QUADS-1:0] tmstrb,
  output logic                 tmstrb_int,
  output logic                 res_valid,
  output logic [4:0]           res_ch,
  output logic [11:0]          res_data,
  output logic                 sweep_done,
  output logic                 timeout_err
);

  // Terminal counts. The cycle in which the counter equals one of these is the
  // last cycle spent in STROBE, or the last cycle CONVERT waits for DATAVALID.
  localparam logic [31:0] STROBE_LAST  = 32'(STROBE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  seq_state_e state;
  seq_state_e state_next;

  logic [4:0]  ch;
  logic [31:0] mask;
  logic [31:0] cnt;

  chan_kind_e  kind;
  logic [3:0]  quad;

  logic ch_hit;
  logic last_ch;
  logic strobe_done;
  logic timeout_hit;
  logic conv_end;
  logic strobe_window;

  adc_chan_decode u_decode (
    .ch   (ch),
    .kind (kind),
    .quad (quad)
  );

  assign ch_hit      = mask[ch];
  assign last_ch     = (ch == 5'(CH_INT_TEMP));
  assign strobe_done = (cnt == STROBE_LAST);
  // When DATAVALID arrives in the same cycle the counter expires, the conversion
  // is treated as successful and no timeout is raised.
  assign timeout_hit = (state == CONVERT) && !ADC_DATAVALID && (cnt == TIMEOUT_LAST);
  assign conv_end    = (state == CONVERT) && (ADC_DATAVALID || timeout_hit);

  // State register.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state <= CAL_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Enable is checked only where a sweep may be abandoned
  // cleanly. Once START is reached, the conversion runs to completion.
  always_comb begin
    state_next = state;
    unique case (state)
      CAL_WAIT: begin
        if (!ADC_CALIBRATE) state_next = IDLE;
      end
      IDLE: begin
        if (enable && (ch_mask != '0)) state_next = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (ch_hit) begin
          state_next = kind_has_strobe(kind) ? STROBE : START;
        end else if (last_ch) begin
          state_next = DONE;
        end
      end
      STROBE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (strobe_done) begin
          state_next = START;
        end
      end
      START: begin
        if (!ADC_BUSY) state_next = CONVERT;
      end
      CONVERT: begin
        if (conv_end) begin
          if (!enable) begin
            state_next = IDLE;
          end else if (last_ch) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = CAL_WAIT;
      end
    endcase
  end

  // Channel pointer, latched mask, the shared settle/timeout counter and ADC_CHNUM.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      ch        <= '0;
      mask      <= '0;
      cnt       <= '0;
      ADC_CHNUM <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (state_next == SCAN) begin
            mask <= ch_mask;
            ch   <= '0;
          end
        end
        SCAN: begin
          if ((state_next == STROBE) || (state_next == START)) begin
            ADC_CHNUM <= ch;
            cnt       <= '0;
          end else if (state_next == SCAN) begin
            ch <= ch + 5'd1;
          end
        end
        STROBE: begin
          cnt <= cnt + 32'd1;
        end
        START: begin
          cnt <= '0;
        end
        CONVERT: begin
          if (conv_end) begin
            cnt <= '0;
            if (state_next == SCAN) ch <= ch + 5'd1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Registered result and timeout pulses. res_ch and res_data hold between results.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      res_valid   <= (state == CONVERT) && ADC_DATAVALID;
      timeout_err <= timeout_hit;
      if ((state == CONVERT) && ADC_DATAVALID) begin
        res_ch   <= ADC_CHNUM;
        res_data <= ADC_RESULT;
      end
    end
  end

  // State-decoded outputs. The strobe covers STROBE, START and CONVERT, and only
  // the one bit belonging to the current channel is ever set.
  always_comb begin
    ADC_START     = 1'b0;
    sweep_done    = 1'b0;
    cmstrb        = '0;
    tmstrb        = '0;
    tmstrb_int    = 1'b0;
    strobe_window = (state == STROBE) || (state == START) || (state == CONVERT);
    if ((state == START) && !ADC_BUSY) ADC_START = 1'b1;
    if (state == DONE) sweep_done = 1'b1;
    if (strobe_window) begin
      case (kind)
        CURRENT:  cmstrb[quad] = 1'b1;
        TEMP:     tmstrb[quad] = 1'b1;
        TEMP_INT: tmstrb_int   = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Autonomous sweep controller for the Fusion analogue block ADC. It walks a latched 32-bit channel mask and drives the ADC start/channel handshake. It asserts the matching current-monitor or temperature-monitor strobe for a settle period before each conversion, then emits one tagged 12-bit result per enabled channel. It sits between the analogue infrastructure wrapper (ADC_*, cmstrb, tmstrb, tmstrb_int) and the monitor register/alarm logic that consumes results.

## Interface
- STROBE_CYCLES, 1600: strobe-to-start settle time in SYS_CLK cycles (≥1).
- TIMEOUT_CYCLES, 65535: maximum cycles from ADC_START to DATAVALID before the conversion is abandoned.
- SYS_CLK  in  1  system clock; sole clock.
- SYS_RST  in  1  reset, synchronous, active-high.
- enable  in  1  level; sweep repeatedly while high.
- ch_mask  in  32  bit n enables ADC channel n; latched at sweep start.
- ADC_START  out  1  one-cycle conversion start pulse.
- ADC_CHNUM  out  5  channel under conversion.
- ADC_CALIBRATE, ADC_BUSY, ADC_DATAVALID  in  1 each  ADC status.
- ADC_RESULT  in  12  conversion result.
- cmstrb  out  10  current-monitor strobes, quad 0–9.
- tmstrb  out  10  temperature-monitor strobes, quad 0–9.
- tmstrb_int  out  1  internal temperature strobe.
- res_valid  out  1  one-cycle result pulse.
- res_ch  out  5  channel of the result.
- res_data  out  12  result value.
- sweep_done  out  1  one-cycle pulse at end of each sweep.
- timeout_err  out  1  one-cycle pulse when a conversion times out.

## Operation
- Channel map: ch0 = direct/ref, no strobe. For quad q (0–9): AV = 3q+1 (no strobe), AC = 3q+2 (cmstrb[q]), AT = 3q+3 (tmstrb[q]). ch31 = internal temperature (tmstrb_int).
- States:
  - CAL_WAIT: entered after reset; stays while ADC_CALIBRATE=1; then → IDLE.
  - IDLE: when enable=1 and ch_mask≠0 → latch mask, ch=0, SCAN. With mask=0 it stays IDLE and no sweep_done is produced.
  - SCAN: examines one channel per cycle. Masked-off channel → ch+1. Enabled channel with a strobe → STROBE. Enabled channel without a strobe → START. After examining ch31 → sweep_done pulse, then IDLE.
  - STROBE: the channel's strobe is high; counts STROBE_CYCLES, then → START.
  - START: waits for ADC_BUSY=0; asserts ADC_START for one cycle; → CONVERT.
  - CONVERT: on ADC_DATAVALID, capture ADC_RESULT and go to the next channel. If the timeout counter reaches TIMEOUT_CYCLES first, pulse timeout_err, emit no result, and go to the next channel.
- The strobe stays high from STROBE entry through the end of CONVERT. At most one strobe bit is high at any time.
- ADC_CHNUM is updated on leaving SCAN and is stable through CONVERT.
- Enable falling mid-sweep: the current conversion always completes (result emitted), then → IDLE without sweep_done. If enable falls while in SCAN or STROBE, → IDLE immediately and strobes drop.
- ch_mask changes mid-sweep are ignored until the next sweep.
- DATAVALID outside CONVERT is ignored.

## Timing
- Reset values: all outputs 0, state CAL_WAIT, counters 0.
- ADC_DATAVALID at cycle t → res_valid, res_ch, res_data registered at t+1. res_ch/res_data hold until the next result.
- STROBE entry at cycle t → ADC_START at t+STROBE_CYCLES at the earliest (BUSY low).
- Non-strobed channel: SCAN hit at t → ADC_START at t+1 at the earliest.
- sweep_done occurs the cycle after ch31 is examined. The next sweep's first SCAN starts 2 cycles after sweep_done if enable=1.
- DATAVALID and timeout expiry in the same cycle: DATAVALID wins and no timeout_err is raised.

## Structure
- Package adc_seq_pkg holds:
  - state enum;
  - channel-kind enum (NONE, CURRENT, TEMP, TEMP_INT);
  - constants CH_INT_TEMP=31 and NUM_QUADS=10.
- Sub-module adc_chan_decode: combinational ch[4:0] → {kind, quad[3:0]}, shared with the alarm logic.

## Test plan
- Calibration gate: hold ADC_CALIBRATE=1 for 100 cycles with enable=1 → no ADC_START until calibration drops; first start follows.
- mask=0x0000_0006: ch1 converts with no strobe. ch2 raises cmstrb[0] and ADC_START follows exactly STROBE_CYCLES later. Results are tagged res_ch=1 then 2, then sweep_done.
- mask=0x8000_0008: tmstrb[0] is used for ch3 and tmstrb_int for ch31. ADC model returns 0xABC → res_data=0xABC on res_ch=31.
- ADC model never asserts DATAVALID on ch4 (mask=0x30) → timeout_err pulse after TIMEOUT_CYCLES, no result for ch4, ch5 still converts.
- Drop enable during CONVERT of ch2 → result for ch2 is emitted, no further ADC_START, no sweep_done. Assert SYS_RST mid-STROBE → all strobes 0 the next cycle, state CAL_WAIT.
